// File: rtl/cfg_dispatch_if.sv
// Command handoff from the UART frame decoder to the configuration dispatcher.
interface cfg_dispatch_if;
  logic        cmd_valid;
  logic [1:0]  cmd_addr;
  logic [5:0]  cmd_mod;
  logic [23:0] cmd_data;

  modport master (output cmd_valid, cmd_addr, cmd_mod, cmd_data);
  modport slave  (input  cmd_valid, cmd_addr, cmd_mod, cmd_data);
endinterface

// File: rtl/cfg_dispatch.sv
// Queues decoded config commands in a 4-deep FIFO and shifts them out one at a
// time on the shared SCLK/SDATA/LE bus, followed by a trigger pulse.
module cfg_dispatch #(
  parameter logic [7:0] CLK_DIV    = 8'd4,
  parameter logic [7:0] LE_CYCLES  = 8'd10,
  parameter logic [7:0] TRP_CYCLES = 8'd10,
  parameter logic [7:0] GAP_CYCLES = 8'd4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  cfg_dispatch_if.slave     cmd,
  input  logic              sticky_clr,
  output logic              ser_sclk,
  output logic              ser_sdata,
  output logic [2:0]        ser_le,
  output logic              trp,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fifo_level,
  output logic              overflow,
  output logic              bad_cmd,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned BITS   = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_TRIG, S_GAP
  } state_t;

  state_t              state, state_d;
  logic [7:0]          cnt, cnt_d;
  logic [5:0]          bit_cnt, bit_cnt_d;
  logic [WORD_W-1:0]   shreg, shreg_d;
  logic [1:0]          addr_q, addr_d;
  logic                sclk_d, sdata_d, trp_d, done_d, pop;
  logic [2:0]          le_d;

  logic [WORD_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                fifo_full, bad_set, ovf_set, wr_en;

  assign fifo_full = (fifo_level == 3'(DEPTH));
  assign bad_set   = cmd.cmd_valid && (cmd.cmd_addr == 2'd3);
  assign ovf_set   = cmd.cmd_valid && (cmd.cmd_addr != 2'd3) && fifo_full && !pop;
  assign wr_en     = cmd.cmd_valid && (cmd.cmd_addr != 2'd3) && (!fifo_full || pop);

  // FIFO storage; only read when fifo_level says the slot is valid
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= {cmd.cmd_addr, cmd.cmd_mod, cmd.cmd_data};
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 2'd1;
      if (pop)   rd_ptr <= rd_ptr + 2'd1;
      fifo_level <= fifo_level + 3'(wr_en) - 3'(pop);
    end
  end

  // Sticky error flags; a clear beats a same-cycle set
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      overflow <= 1'b0;
      bad_cmd  <= 1'b0;
      drop_cnt <= '0;
    end else if (sticky_clr) begin
      overflow <= 1'b0;
      bad_cmd  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      if (bad_set) bad_cmd  <= 1'b1;
      if ((ovf_set || bad_set) && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Next-state and next-output logic; bus outputs are registered from these
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    addr_d    = addr_q;
    sclk_d    = 1'b0;
    sdata_d   = 1'b0;
    le_d      = '0;
    trp_d     = 1'b0;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_level != 3'd0) begin
          pop     = 1'b1;
          state_d = S_LOAD;
          shreg_d = mem[rd_ptr];
          addr_d  = mem[rd_ptr][31:30];
          sdata_d = mem[rd_ptr][31];
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        cnt_d     = '0;
        bit_cnt_d = '0;
        sdata_d   = shreg[31];
      end
      S_SHIFT: begin
        sdata_d = shreg[31];
        sclk_d  = ser_sclk;
        cnt_d   = cnt + 8'd1;
        if (cnt == CLK_DIV - 8'd1) begin
          cnt_d = '0;
          if (!ser_sclk) begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt + 6'd1;
          end else if (bit_cnt == 6'(BITS)) begin
            state_d = S_LATCH;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
            le_d    = 3'(1) << addr_q;
          end else begin
            // falling edge: advance to the next bit so it settles before the rise
            sclk_d  = 1'b0;
            shreg_d = {shreg[30:0], 1'b0};
            sdata_d = shreg[30];
          end
        end
      end
      S_LATCH: begin
        le_d  = 3'(1) << addr_q;
        cnt_d = cnt + 8'd1;
        if (cnt == LE_CYCLES - 8'd1) begin
          state_d = S_TRIG;
          cnt_d   = '0;
          le_d    = '0;
          trp_d   = 1'b1;
        end
      end
      S_TRIG: begin
        trp_d = 1'b1;
        cnt_d = cnt + 8'd1;
        if (cnt == TRP_CYCLES - 8'd1) begin
          state_d = S_GAP;
          cnt_d   = '0;
          trp_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt + 8'd1;
        if (cnt == GAP_CYCLES - 8'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      ser_sclk  <= 1'b0;
      ser_sdata <= 1'b0;
      ser_le    <= '0;
      trp       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      addr_q    <= addr_d;
      ser_sclk  <= sclk_d;
      ser_sdata <= sdata_d;
      ser_le    <= le_d;
      trp       <= trp_d;
      done      <= done_d;
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cfg_dispatch.sv
// Directed bench for cfg_dispatch: default instance plus a CLK_DIV=1 instance.
module tb_cfg_dispatch;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  cfg_dispatch_if cmd_a ();
  cfg_dispatch_if cmd_b ();
  logic sticky_a, sticky_b;

  logic       a_sclk, a_sdata, a_trp, a_busy, a_done, a_ovf, a_bad;
  logic [2:0] a_le, a_level;
  logic [7:0] a_drop;
  logic       b_sclk, b_sdata, b_trp, b_busy, b_done, b_ovf, b_bad;
  logic [2:0] b_le, b_level;
  logic [7:0] b_drop;

  cfg_dispatch u_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd(cmd_a), .sticky_clr(sticky_a),
    .ser_sclk(a_sclk), .ser_sdata(a_sdata), .ser_le(a_le), .trp(a_trp),
    .busy(a_busy), .done(a_done), .fifo_level(a_level), .overflow(a_ovf),
    .bad_cmd(a_bad), .drop_cnt(a_drop)
  );

  cfg_dispatch #(.CLK_DIV(8'd1)) u_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd(cmd_b), .sticky_clr(sticky_b),
    .ser_sclk(b_sclk), .ser_sdata(b_sdata), .ser_le(b_le), .trp(b_trp),
    .busy(b_busy), .done(b_done), .fifo_level(b_level), .overflow(b_ovf),
    .bad_cmd(b_bad), .drop_cnt(b_drop)
  );

  logic       sel_b;
  logic       m_sclk, m_sdata, m_trp, m_busy, m_done;
  logic [2:0] m_le, m_level;
  assign m_sclk  = sel_b ? b_sclk  : a_sclk;
  assign m_sdata = sel_b ? b_sdata : a_sdata;
  assign m_trp   = sel_b ? b_trp   : a_trp;
  assign m_busy  = sel_b ? b_busy  : a_busy;
  assign m_done  = sel_b ? b_done  : a_done;
  assign m_le    = sel_b ? b_le    : a_le;
  assign m_level = sel_b ? b_level : a_level;

  int checks = 0;
  int errors = 0;

  // Per-transfer observations
  int          rises, first_rise, le_first, le_len, trp_first, trp_len;
  int          done_cnt, done_cycle, idle_cycle, busy_cnt;
  logic [31:0] word;
  logic [2:0]  le_val, le_or;
  logic [2:0]  lvl1, lvl2;
  logic        sd2, busy2, timed_out;

  logic [31:0] exp_w [5];
  logic [2:0]  exp_le[5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [1:0] a, input logic [5:0] m, input logic [23:0] d);
    cmd_a.cmd_valid = 1'b1; cmd_a.cmd_addr = a; cmd_a.cmd_mod = m; cmd_a.cmd_data = d;
    @(negedge sys_clk);
    cmd_a.cmd_valid = 1'b0;
  endtask

  task automatic push_b(input logic [1:0] a, input logic [5:0] m, input logic [23:0] d);
    cmd_b.cmd_valid = 1'b1; cmd_b.cmd_addr = a; cmd_b.cmd_mod = m; cmd_b.cmd_data = d;
    @(negedge sys_clk);
    cmd_b.cmd_valid = 1'b0;
  endtask

  // Observe one transfer from the current negedge (numbered 'start') until idle after done
  task automatic run_xfer(input int start, input int budget);
    logic prev;
    int   c;
    rises = 0; word = '0; first_rise = -1; le_first = -1; le_len = 0; le_val = '0;
    le_or = '0; trp_first = -1; trp_len = 0; done_cnt = 0; done_cycle = -1;
    idle_cycle = -1; busy_cnt = 0; lvl1 = '0; lvl2 = '0; sd2 = 1'b0; busy2 = 1'b0;
    timed_out = 1'b0;
    prev = m_sclk;
    c = start;
    forever begin
      if (c == 1) lvl1 = m_level;
      if (c == 2) begin lvl2 = m_level; sd2 = m_sdata; busy2 = m_busy; end
      if (m_sclk && !prev) begin
        rises++;
        word = {word[30:0], m_sdata};
        if (first_rise < 0) first_rise = c;
      end
      prev = m_sclk;
      if (m_le != 3'd0) begin
        if (le_first < 0) begin le_first = c; le_val = m_le; end
        le_len++;
      end
      le_or = le_or | m_le;
      if (m_trp) begin
        if (trp_first < 0) trp_first = c;
        trp_len++;
      end
      if (m_busy) busy_cnt++;
      if (m_done) begin done_cnt++; done_cycle = c; end
      if (done_cnt > 0 && !m_busy) begin idle_cycle = c; break; end
      if (c - start >= budget) begin timed_out = 1'b1; break; end
      @(negedge sys_clk);
      c++;
    end
  endtask

  initial begin
    sel_b = 1'b0;
    sticky_a = 1'b0; sticky_b = 1'b0;
    cmd_a.cmd_valid = 1'b0; cmd_a.cmd_addr = '0; cmd_a.cmd_mod = '0; cmd_a.cmd_data = '0;
    cmd_b.cmd_valid = 1'b0; cmd_b.cmd_addr = '0; cmd_b.cmd_mod = '0; cmd_b.cmd_data = '0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("reset_a", 64'({a_sclk, a_sdata, a_le, a_trp, a_busy, a_done, a_level, a_ovf, a_bad, a_drop}), 64'(0));
    chk("reset_b", 64'({b_sclk, b_sdata, b_le, b_trp, b_busy, b_done, b_level, b_ovf, b_bad, b_drop}), 64'(0));
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single command, default timing
    push_a(2'd0, 6'h01, 24'h123456);
    run_xfer(1, 400);
    chk("t1_timeout",   64'(timed_out), 64'(0));
    chk("t1_level_c1",  64'(lvl1), 64'(1));
    chk("t1_level_c2",  64'(lvl2), 64'(0));
    chk("t1_busy_load", 64'(busy2), 64'(1));
    chk("t1_sdata_load",64'(sd2), 64'(0));
    chk("t1_first_rise",64'(first_rise), 64'(7));
    chk("t1_rises",     64'(rises), 64'(32));
    chk("t1_word",      64'(word), 64'(32'h01123456));
    chk("t1_le_first",  64'(le_first), 64'(259));
    chk("t1_le_val",    64'(le_val), 64'(3'b001));
    chk("t1_le_len",    64'(le_len), 64'(10));
    chk("t1_le_or",     64'(le_or), 64'(3'b001));
    chk("t1_trp_first", 64'(trp_first), 64'(269));
    chk("t1_trp_len",   64'(trp_len), 64'(10));
    chk("t1_done_cyc",  64'(done_cycle), 64'(279));
    chk("t1_done_cnt",  64'(done_cnt), 64'(1));
    chk("t1_idle_cyc",  64'(idle_cycle), 64'(283));
    chk("t1_sdata_idle",64'(a_sdata), 64'(0));

    // Address 2 on the CLK_DIV=1 instance
    sel_b = 1'b1;
    push_b(2'd2, 6'h3F, 24'hABCDEF);
    run_xfer(1, 200);
    chk("t2_timeout",   64'(timed_out), 64'(0));
    chk("t2_sdata_load",64'(sd2), 64'(1));
    chk("t2_first_rise",64'(first_rise), 64'(4));
    chk("t2_rises",     64'(rises), 64'(32));
    chk("t2_word",      64'(word), 64'(32'hBFABCDEF));
    chk("t2_le_first",  64'(le_first), 64'(67));
    chk("t2_le_val",    64'(le_val), 64'(3'b100));
    chk("t2_le_or",     64'(le_or), 64'(3'b100));
    chk("t2_trp_first", 64'(trp_first), 64'(77));
    chk("t2_done_cyc",  64'(done_cycle), 64'(87));
    chk("t2_idle_cyc",  64'(idle_cycle), 64'(91));
    sel_b = 1'b0;

    // Six back-to-back commands while a transfer is shifting
    @(negedge sys_clk);
    push_a(2'd1, 6'h05, 24'h00A5A5);
    repeat (20) @(negedge sys_clk);
    for (int i = 0; i < 6; i++) begin
      cmd_a.cmd_valid = 1'b1;
      cmd_a.cmd_addr  = 2'(i % 3 + 1 == 3 ? 0 : i % 3 + 1);
      cmd_a.cmd_mod   = 6'(i + 1);
      cmd_a.cmd_data  = {6{4'(i + 1)}};
      @(negedge sys_clk);
    end
    cmd_a.cmd_valid = 1'b0;
    chk("t3_level_full", 64'(a_level), 64'(4));
    chk("t3_overflow",   64'(a_ovf), 64'(1));
    chk("t3_drop_cnt",   64'(a_drop), 64'(2));
    chk("t3_bad_cmd",    64'(a_bad), 64'(0));
    exp_w[0] = 32'h41111111; exp_le[0] = 3'b010;
    exp_w[1] = 32'h82222222; exp_le[1] = 3'b100;
    exp_w[2] = 32'h03333333; exp_le[2] = 3'b001;
    exp_w[3] = 32'h44444444; exp_le[3] = 3'b010;
    run_xfer(0, 400);
    chk("t3_x_timeout", 64'(timed_out), 64'(0));
    for (int k = 0; k < 4; k++) begin
      run_xfer(1, 400);
      chk($sformatf("t3_q%0d_timeout", k), 64'(timed_out), 64'(0));
      chk($sformatf("t3_q%0d_word", k),    64'(word), 64'(exp_w[k]));
      chk($sformatf("t3_q%0d_le", k),      64'(le_or), 64'(exp_le[k]));
      if (k == 0) begin
        chk("t3_b2b_done", 64'(done_cycle), 64'(279));
        chk("t3_b2b_idle", 64'(idle_cycle), 64'(283));
      end
    end
    chk("t3_drained", 64'(a_level), 64'(0));
    sticky_a = 1'b1;
    @(negedge sys_clk);
    sticky_a = 1'b0;
    chk("t3_clr_ovf",  64'(a_ovf), 64'(0));
    chk("t3_clr_drop", 64'(a_drop), 64'(0));

    // Push on a full FIFO in the same cycle as a pop
    push_a(2'd0, 6'h0A, 24'h0000AA);
    repeat (20) @(negedge sys_clk);
    push_a(2'd2, 6'h10, 24'h000001);
    push_a(2'd1, 6'h20, 24'h000002);
    push_a(2'd0, 6'h30, 24'h000003);
    push_a(2'd2, 6'h3F, 24'h000004);
    chk("t4_level_pre", 64'(a_level), 64'(4));
    run_xfer(0, 400);
    chk("t4_x_timeout", 64'(timed_out), 64'(0));
    chk("t4_pop_level", 64'(a_level), 64'(4));
    push_a(2'd1, 6'h01, 24'hC0FFEE);
    chk("t4_level_same", 64'(a_level), 64'(4));
    chk("t4_no_ovf",     64'(a_ovf), 64'(0));
    chk("t4_no_drop",    64'(a_drop), 64'(0));
    exp_w[0] = 32'h90000001; exp_le[0] = 3'b100;
    exp_w[1] = 32'h60000002; exp_le[1] = 3'b010;
    exp_w[2] = 32'h30000003; exp_le[2] = 3'b001;
    exp_w[3] = 32'hBF000004; exp_le[3] = 3'b100;
    exp_w[4] = 32'h41C0FFEE; exp_le[4] = 3'b010;
    for (int k = 0; k < 5; k++) begin
      run_xfer(k == 0 ? 2 : 1, 400);
      chk($sformatf("t4_q%0d_word", k), 64'(word), 64'(exp_w[k]));
      chk($sformatf("t4_q%0d_le", k),   64'(le_or), 64'(exp_le[k]));
    end

    // Illegal address, sticky clear priority, and drop counter saturation
    @(negedge sys_clk);
    push_a(2'd3, 6'h11, 24'h111111);
    chk("t5_level",   64'(a_level), 64'(0));
    chk("t5_bad",     64'(a_bad), 64'(1));
    chk("t5_drop",    64'(a_drop), 64'(1));
    chk("t5_ovf",     64'(a_ovf), 64'(0));
    chk("t5_busy",    64'(a_busy), 64'(0));
    sticky_a = 1'b1;
    push_a(2'd3, 6'h12, 24'h222222);
    sticky_a = 1'b0;
    chk("t5_clr_bad",  64'(a_bad), 64'(0));
    chk("t5_clr_drop", 64'(a_drop), 64'(0));
    cmd_a.cmd_valid = 1'b1; cmd_a.cmd_addr = 2'd3;
    repeat (260) @(negedge sys_clk);
    cmd_a.cmd_valid = 1'b0;
    chk("t5_drop_sat", 64'(a_drop), 64'(255));
    chk("t5_sat_lvl",  64'(a_level), 64'(0));
    sticky_a = 1'b1;
    @(negedge sys_clk);
    sticky_a = 1'b0;

    // Reset in the middle of bit 10
    push_a(2'd1, 6'h2A, 24'hFFFFFF);
    push_a(2'd2, 6'h01, 24'h000000);
    push_a(2'd3, 6'h00, 24'h000000);
    repeat (76) @(negedge sys_clk);
    chk("t6_pre_sclk",  64'(a_sclk), 64'(1));
    chk("t6_pre_sdata", 64'(a_sdata), 64'(1));
    chk("t6_pre_level", 64'(a_level), 64'(1));
    chk("t6_pre_bad",   64'(a_bad), 64'(1));
    #2 sys_rst = 1'b0;
    #1;
    chk("t6_rst_a", 64'({a_sclk, a_sdata, a_le, a_trp, a_busy, a_done, a_level, a_ovf, a_bad, a_drop}), 64'(0));
    chk("t6_rst_b", 64'({b_sclk, b_sdata, b_le, b_trp, b_busy, b_done, b_level, b_ovf, b_bad, b_drop}), 64'(0));
    @(negedge sys_clk);
    sys_rst = 1'b1;
    run_xfer(0, 300);
    chk("t6_post_idle",  64'(timed_out), 64'(1));
    chk("t6_post_le",    64'(le_or), 64'(0));
    chk("t6_post_trp",   64'(trp_len), 64'(0));
    chk("t6_post_sclk",  64'(rises), 64'(0));
    chk("t6_post_busy",  64'(busy_cnt), 64'(0));
    chk("t6_post_level", 64'(a_level), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_dispatch.md
# cfg_dispatch

Command scheduler between the UART frame decoder and the on-board configuration targets (frequency synthesizer at address 0, up-converter channels at addresses 1 and 2). It queues decoded commands (address, mode select, 24-bit data) in a 4-entry FIFO and serializes them one at a time onto a shared 3-wire bus (SCLK/SDATA plus a per-target latch enable). After each latch it issues a trigger pulse. Commands arriving while a transfer is in flight are buffered, never lost, until the FIFO is full.

## Interface
- CLK_DIV, 8'd4: sys_clk cycles per SCLK half-period (valid range 1..255).
- LE_CYCLES, 8'd10: latch-enable high time in cycles (200 ns at 50 MHz).
- TRP_CYCLES, 8'd10: trigger pulse width in cycles.
- GAP_CYCLES, 8'd4: idle cycles enforced between consecutive transfers.

- sys_clk  in  1  system clock (50 MHz); single clock domain.
- sys_rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  one-cycle command strobe from the decoder's received_done.
- cmd_addr  in  2  target address; 3 is illegal.
- cmd_mod  in  6  mode select.
- cmd_data  in  24  configuration data.
- sticky_clr  in  1  synchronous clear of overflow, bad_cmd, drop_cnt.
- ser_sclk  out  1  serial clock, idle low.
- ser_sdata  out  1  serial data, MSB first.
- ser_le  out  3  one-hot latch enable, bit n = target n.
- trp  out  1  trigger pulse after latch.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse per completed transfer.
- fifo_level  out  3  queued entries, 0..4.
- overflow  out  1  sticky: a command was dropped because the FIFO was full.
- bad_cmd  out  1  sticky: a command with address 3 was rejected.
- drop_cnt  out  8  saturating count of dropped and rejected commands.

## Operation
- Reset values: all outputs 0 and the FIFO empty. Asserting sys_rst mid-transfer aborts it at once; SCLK, SDATA, LE and trp return low asynchronously.
- Write rules on cmd_valid:
  - cmd_addr==3: not written; set bad_cmd; drop_cnt++.
  - FIFO full with no pop in the same cycle: not written; set overflow; drop_cnt++.
  - FIFO full with a pop in the same cycle: written; level unchanged.
- drop_cnt saturates at 255.
- sticky_clr wins over a same-cycle set.
- FIFO word is 32 bits: {cmd_addr, cmd_mod, cmd_data}. Read and write pointers are 2 bits and wrap.
- FSM states: IDLE, LOAD, SHIFT, LATCH, TRIG, GAP.
  - IDLE: if fifo_level!=0, pop the head and go to LOAD.
  - LOAD, 1 cycle: the shift register takes the word; the address is held; ser_sdata = bit 31.
  - SHIFT: per bit, SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. The shift and the next SDATA update occur on the cycle SCLK returns low, so SDATA is stable across each rising edge. After 32 rising edges SCLK is low and the FSM goes to LATCH. SHIFT lasts exactly 64*CLK_DIV cycles.
  - LATCH: ser_le[addr] high for LE_CYCLES, then TRIG.
  - TRIG: trp high for TRP_CYCLES, then GAP; done pulses on the first GAP cycle.
  - GAP: GAP_CYCLES cycles, then IDLE.
- ser_sdata is 0 outside LOAD and SHIFT. The FIFO accepts writes in every state.

## Timing
- Counting cycle 0 as the cmd_valid cycle, with the FIFO empty and the FSM in IDLE:
  - fifo_level=1 in cycle 1.
  - Pop in cycle 1; fifo_level=0 in cycle 2.
  - LOAD in cycle 2.
  - First SCLK rise at cycle 3+CLK_DIV.
  - LE rises at cycle 3+64*CLK_DIV.
  - trp rises LE_CYCLES later.
  - done asserts at cycle 3+64*CLK_DIV+LE_CYCLES+TRP_CYCLES.
- Back-to-back: the next LOAD follows GAP_CYCLES+1 cycles after done.
- Total period per command: 3+64*CLK_DIV+LE_CYCLES+TRP_CYCLES+GAP_CYCLES cycles.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Single command, defaults, {addr 0, mod 6'h01, data 24'h123456}:
  - SDATA over 32 SCLK rises reads 32'h01123456.
  - ser_le=3'b001 for 10 cycles, then trp for 10 cycles, then one done; no other ser_le bit ever toggles.
- Addr 2, CLK_DIV=1:
  - SHIFT is 64 cycles; ser_le=3'b100.
  - Latch-to-done timing matches the Timing formula exactly.
- Six commands in consecutive cycles during an active transfer:
  - Four queued; overflow=1; drop_cnt=2 (or 1 if a pop coincides).
  - Remaining commands go out in FIFO order with the data intact.
- Push on a full FIFO coincident with a pop: the command is accepted, fifo_level stays 4, overflow stays 0.
- cmd_addr=3: nothing is queued; bad_cmd=1; drop_cnt increments. Then sticky_clr in the same cycle as another illegal command leaves bad_cmd=0 and drop_cnt=0.
- sys_rst low during SHIFT bit 10: all outputs 0 immediately. After release the FSM is IDLE, fifo_level=0, and no LE or trp pulse is generated.
